// File: rtl/clm_host_bridge.sv
// clm_host_bridge: byte-serial initiator front end for one CLM AES core.
// Collects key (bytes 0-15) and plaintext (bytes 16-31), fires a one-cycle
// start pulse, waits for the core with a timeout, then streams the 16-byte
// ciphertext out. All outputs are registered from the next-state values.
//
// The core's vectors use [0:127] ordering (bit 0 is the MSB). Here they are
// carried as [127:0] with the same numeric value, so vector byte k sits at
// bits [127-8k -: 8] and byte 0 is the most significant byte.
module clm_host_bridge #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  output logic [127:0] core_key,
  output logic [127:0] core_plaintext,
  output logic         core_drdy_i,
  input  logic [127:0] core_ciphertext,
  input  logic         core_drdy_o,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_data,
  output logic         m_last,
  output logic         busy,
  output logic         timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Bit position of the least significant bit of vector byte k.
  function automatic logic [6:0] byte_lsb(input logic [3:0] k);
    return {4'd15 - k, 3'b000};
  endfunction

  // Read vector byte k (byte 0 = most significant).
  function automatic logic [7:0] byte_get(input logic [127:0] v, input logic [3:0] k);
    return v[byte_lsb(k) +: 8];
  endfunction

  // Return v with vector byte k replaced by b.
  function automatic logic [127:0] byte_put(input logic [127:0] v, input logic [3:0] k,
                                            input logic [7:0] b);
    logic [127:0] r;
    r = v;
    r[byte_lsb(k) +: 8] = b;
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    pt_q, pt_d;
  logic [127:0]    ct_q, ct_d;
  logic            terr_q, terr_d;
  logic            s_ready_q, s_ready_d;
  logic            drdy_i_q, drdy_i_d;
  logic            m_valid_q, m_valid_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            busy_q, busy_d;
  logic            s_beat, m_beat;

  assign s_beat = s_valid && s_ready_q;
  assign m_beat = m_valid_q && m_ready;

  // Next-state logic: byte collection, start, timed wait and ciphertext drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    terr_d  = terr_q;
    case (state_q)
      ST_LOAD: begin
        if (s_beat) begin
          if (idx_q[4]) begin
            pt_d = byte_put(pt_q, idx_q[3:0], s_data);
          end else begin
            key_d = byte_put(key_q, idx_q[3:0], s_data);
          end
          if (idx_q == 5'd31) begin
            idx_d   = 5'd0;
            // Cleared here so the flag already reads 0 during the FIRE cycle.
            terr_d  = 1'b0;
            state_d = ST_FIRE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FIRE: begin
        cnt_d   = CNT_ZERO;
        terr_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the final counted cycle still wins over the timeout.
        if (core_drdy_o) begin
          ct_d    = core_ciphertext;
          state_d = ST_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (m_beat) begin
          if (idx_q == 5'd15) begin
            idx_d   = 5'd0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = 5'd0;
      end
    endcase
  end

  // Output decode from the next state so every port is driven by a flop.
  always_comb begin
    s_ready_d = (state_d == ST_LOAD);
    drdy_i_d  = (state_d == ST_FIRE);
    busy_d    = (state_d != ST_LOAD);
    m_valid_d = (state_d == ST_DRAIN);
    if (state_d == ST_DRAIN) begin
      m_data_d = byte_get(ct_d, idx_d[3:0]);
      m_last_d = (idx_d == 5'd15);
    end else begin
      m_data_d = 8'd0;
      m_last_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      idx_q     <= 5'd0;
      cnt_q     <= CNT_ZERO;
      key_q     <= 128'd0;
      pt_q      <= 128'd0;
      ct_q      <= 128'd0;
      terr_q    <= 1'b0;
      s_ready_q <= 1'b0;
      drdy_i_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      terr_q    <= terr_d;
      s_ready_q <= s_ready_d;
      drdy_i_q  <= drdy_i_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign core_drdy_i    = drdy_i_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign m_last         = m_last_q;
  assign busy           = busy_q;
  assign timeout_err    = terr_q;

endmodule

// File: doc/clm_host_bridge.md
# clm_host_bridge

Byte-serial host-side front end for the CLM AES core: the initiator end of the core's plaintext/key/ciphertext handshake. It collects a 16-byte key and a 16-byte plaintext from a narrow valid/ready stream and launches one encryption with a single-cycle `drdy_i` pulse. It then waits, with a timeout, for the core's `drdy_o`, and streams the 16-byte ciphertext back out byte by byte. It sits between a host bus or test harness and one CLM core instance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT cycles before the block abandons the job. Legal values are 1 or more.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: reset, synchronous and active-low. `rst=0` at a rising edge resets the block.
- `s_valid`  in  1: input byte valid.
- `s_ready`  out  1: block accepts an input byte.
- `s_data`  in  8: input byte.
- `core_key`  out  128: key to the core, `[0:127]` ordering.
- `core_plaintext`  out  128: plaintext to the core, `[0:127]` ordering.
- `core_drdy_i`  out  1: start pulse to the core.
- `core_ciphertext`  in  128: result from the core.
- `core_drdy_o`  in  1: result-valid flag from the core.
- `m_valid`  out  1: output byte valid.
- `m_ready`  in  1: downstream accepts the output byte.
- `m_data`  out  8: ciphertext byte.
- `m_last`  out  1: marks the 16th ciphertext byte.
- `busy`  out  1: high in FIRE, WAIT and DRAIN.
- `timeout_err`  out  1: sticky flag, set when the core does not respond in time.

## Operation
- FSM states: LOAD, FIRE, WAIT, DRAIN.
- LOAD:
  - `s_ready=1`.
  - Each beat with `s_valid&&s_ready` stores `s_data` at byte index `idx` (5-bit counter, 0..31) and increments `idx`.
  - Bytes 0–15 fill `core_key`; bytes 16–31 fill `core_plaintext`.
  - Byte k of a vector occupies bits `[8k:8k+7]`, so byte 0 is the most significant byte.
  - Accepting byte 31 moves the FSM to FIRE and clears `idx` to 0.
- FIRE:
  - Lasts exactly one cycle, with `core_drdy_i=1` and `s_ready=0`.
  - `timeout_err` clears to 0 in this cycle.
  - The timeout counter clears to 0. It is `$clog2(TIMEOUT_CYCLES+1)` bits wide.
  - Next state is WAIT.
- WAIT:
  - If `core_drdy_o=1`, `core_ciphertext` is captured into an internal 128-bit register and the next state is DRAIN.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYCLES-1` and `core_drdy_o=0`, the block sets `timeout_err=1`, discards the job and goes to LOAD.
  - A response arriving in the same cycle as the timeout is taken as a success; the response wins.
- DRAIN:
  - `m_valid=1` and `m_data` is captured-ciphertext byte `idx`.
  - `m_last=1` when `idx==15`.
  - `idx` advances on each `m_valid&&m_ready`.
  - The handshake on byte 15 clears `idx` and returns the FSM to LOAD.
- `core_drdy_o` is ignored outside WAIT, including in the FIRE cycle.
- `core_key` and `core_plaintext` change only on LOAD beats. They are stable from FIRE through the end of WAIT.
- `s_data` is don't-care when `s_valid=0`. The block imposes no requirement on `m_ready` when `m_valid=0`.

## Timing
- Reset values:
  - `s_ready=0`, `core_drdy_i=0`, `m_valid=0`, `m_last=0`, `m_data=0`, `busy=0`, `timeout_err=0`.
  - `core_key=0`, `core_plaintext=0`, internal ciphertext register 0, `idx=0`, state LOAD.
  - `s_ready` rises in the first cycle after `rst` returns high.
- Throughput: one input byte per cycle and one output byte per cycle, with no bubbles inside LOAD or DRAIN.
- Latency:
  - Byte 31 accepted at edge T gives `core_drdy_i=1` in cycle T+1.
  - If `core_drdy_o` is sampled high at WAIT edge W, then `m_valid=1` from cycle W+1.
  - After the last DRAIN handshake, `s_ready=1` in the next cycle.
- Output hold rule: while `m_valid&&!m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops without a handshake.
- Timeout timing: with no response, `timeout_err` rises and `s_ready` rises `TIMEOUT_CYCLES` cycles after the FIRE cycle.
- Reset mid-operation (any state, synchronous): the job is abandoned and all outputs return to their reset values at that edge. No partial `core_drdy_i` pulse or output byte is emitted afterward.
- `busy` is a registered state decode; it is high in FIRE, WAIT and DRAIN.

## Test plan
- FIPS-197 vector:
  - Stimulus: key bytes 00..0f, then plaintext 00 11 22 .. ff. The core model answers 40 cycles after `drdy_i` with `69c4e0d86a7b0430d8cdb78070b4c55a`.
  - Required: `core_key=000102..0f` and `core_plaintext=00112233..ff`; exactly one `core_drdy_i` pulse; `m_data` runs 69, c4, .., 5a with `m_last` only on 5a; `s_ready` high again one cycle later.
- Input gaps and output backpressure:
  - Stimulus: `s_valid` randomly low about 50% of cycles; `m_ready` toggles each cycle.
  - Required: the same 16 output bytes as the FIPS-197 case, with `m_data` stable during every stall.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES=16`; the core never asserts `core_drdy_o`.
  - Required: `timeout_err=1` and `s_ready=1` 16 cycles after FIRE; no `m_valid`.
  - Follow-up: the next job clears `timeout_err` in its FIRE cycle.
- Response on the timeout edge:
  - Stimulus: `core_drdy_o` asserted in the WAIT cycle where the counter is `TIMEOUT_CYCLES-1`.
  - Required: ciphertext is drained and `timeout_err` stays 0.
- Spurious `core_drdy_o`:
  - Stimulus: `core_drdy_o` asserted during LOAD, FIRE and DRAIN.
  - Required: no state change and no capture.
- Reset mid-DRAIN:
  - Stimulus: `rst=0` for one cycle after 5 output bytes.
  - Required: all outputs at reset values on the next cycle; a following full job produces correct output starting from byte 0.
